// File: rtl/bus_command_pkg.sv
// Shared types for the 8288-style bus command generator: CPU status codes,
// sequencer states and the code-class helper used by the decode.
package bus_command_pkg;

  typedef enum logic [2:0] {
    STATUS_INTA       = 3'b000,
    STATUS_IO_READ    = 3'b001,
    STATUS_IO_WRITE   = 3'b010,
    STATUS_HALT       = 3'b011,
    STATUS_CODE_FETCH = 3'b100,
    STATUS_MEM_READ   = 3'b101,
    STATUS_MEM_WRITE  = 3'b110,
    STATUS_PASSIVE    = 3'b111
  } status_t;

  // Raw bit pattern of the passive status, for comparison against the CPU pins.
  localparam logic [2:0] PASSIVE_CODE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_TW,
    ST_T4
  } state_t;

  function automatic logic is_write_code(input status_t code);
    return (code == STATUS_IO_WRITE) || (code == STATUS_MEM_WRITE);
  endfunction

endpackage

// File: rtl/bus_command_generator.sv
// 8288-style bus controller: decodes S2..S0 into ALE, DT/R#, DEN and command strobes.
// Optional macro ADVANCED_WRITE_EN moves write strobe assertion from T3 to T2.
module bus_command_generator
  import bus_command_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 1023,
  parameter int TIMER_WIDTH  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] processor_status,
  input  logic       processor_ready,
  input  logic       address_enable_n,
  output logic       address_latch_enable,
  output logic       processor_transmit_or_receive_n,
  output logic       data_enable,
  output logic       io_read_n,
  output logic       io_write_n,
  output logic       memory_read_n,
  output logic       memory_write_n,
  output logic       interrupt_acknowledge_n,
  output logic       bus_cycle_active,
  output logic       halt_detected,
  output logic       bus_timeout
);

  localparam logic                   TIMEOUT_ON   = (WAIT_TIMEOUT != 0);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(WAIT_TIMEOUT - 1);

  state_t                 state, next_state;
  status_t                code, code_next;
  logic [2:0]             prev_status;
  logic [TIMER_WIDTH-1:0] wait_count;
  logic                   start, timeout_hit, timeout_fire;
  logic                   read_phase, write_phase;

  logic ale_d, dtr_d, den_d, bca_d, halt_d;
  logic io_read_d, io_write_d, mem_read_d, mem_write_d, inta_d;

  logic ale_p1, dtr_p1, den_p1, bca_p1, halt_p1, timeout_p1;
  logic io_read_p1, io_write_p1, mem_read_p1, mem_write_p1, inta_p1;

  always_comb begin
    start        = (processor_status != PASSIVE_CODE) && (prev_status == PASSIVE_CODE) &&
                   ((state == ST_IDLE) || (state == ST_T4));
    code_next    = start ? status_t'(processor_status) : code;
    timeout_hit  = TIMEOUT_ON && (wait_count == TIMEOUT_LAST);
    timeout_fire = 1'b0;
    next_state   = state;

    // READY wins over the timeout when both land on the same Tw clock.
    case (state)
      ST_IDLE: if (start) next_state = ST_T1;
      ST_T1:   next_state = (code == STATUS_HALT) ? ST_IDLE : ST_T2;
      ST_T2:   next_state = ST_T3;
      ST_T3:   next_state = processor_ready ? ST_T4 : ST_TW;
      ST_TW: begin
        if (processor_ready) begin
          next_state = ST_T4;
        end else if (timeout_hit) begin
          next_state   = ST_T4;
          timeout_fire = 1'b1;
        end
      end
      ST_T4:   next_state = start ? ST_T1 : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase

    read_phase = (next_state == ST_T2) || (next_state == ST_T3) || (next_state == ST_TW);
`ifdef ADVANCED_WRITE_EN
    write_phase = read_phase;
`else
    write_phase = (next_state == ST_T3) || (next_state == ST_TW);
`endif

    // Output registers are loaded with the value for the state being entered.
    ale_d       = (next_state == ST_T1);
    dtr_d       = (next_state == ST_T1) ? is_write_code(code_next) : dtr_p1;
    den_d       = read_phase && (code_next != STATUS_HALT);
    bca_d       = (next_state != ST_IDLE);
    halt_d      = (next_state == ST_T1) && (code_next == STATUS_HALT);
    io_read_d   = read_phase && (code_next == STATUS_IO_READ);
    mem_read_d  = read_phase && ((code_next == STATUS_MEM_READ) ||
                                 (code_next == STATUS_CODE_FETCH));
    inta_d      = read_phase && (code_next == STATUS_INTA);
    io_write_d  = write_phase && (code_next == STATUS_IO_WRITE);
    mem_write_d = write_phase && (code_next == STATUS_MEM_WRITE);
  end

  // Stage p1: state, wait counter and registered bus outputs.
  always_ff @(posedge clock) begin
    code <= code_next;
    if (reset) begin
      state        <= ST_IDLE;
      prev_status  <= PASSIVE_CODE;
      wait_count   <= '0;
      ale_p1       <= 1'b0;
      dtr_p1       <= 1'b0;
      den_p1       <= 1'b0;
      bca_p1       <= 1'b0;
      halt_p1      <= 1'b0;
      timeout_p1   <= 1'b0;
      io_read_p1   <= 1'b0;
      io_write_p1  <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      inta_p1      <= 1'b0;
    end else begin
      state       <= next_state;
      prev_status <= processor_status;
      if (next_state == ST_T1) begin
        wait_count <= '0;
      end else if (state == ST_TW) begin
        wait_count <= wait_count + 1'b1;
      end
      ale_p1       <= ale_d;
      dtr_p1       <= dtr_d;
      den_p1       <= den_d;
      bca_p1       <= bca_d;
      halt_p1      <= halt_d;
      timeout_p1   <= timeout_fire;
      io_read_p1   <= io_read_d;
      io_write_p1  <= io_write_d;
      mem_read_p1  <= mem_read_d;
      mem_write_p1 <= mem_write_d;
      inta_p1      <= inta_d;
    end
  end

  // DMA ownership gates ALE and every command strobe without disturbing the sequencer.
  assign address_latch_enable            = ale_p1 & address_enable_n;
  assign processor_transmit_or_receive_n = dtr_p1;
  assign data_enable                     = den_p1;
  assign bus_cycle_active                = bca_p1;
  assign halt_detected                   = halt_p1;
  assign bus_timeout                     = timeout_p1;
  assign io_read_n                       = ~(io_read_p1 & address_enable_n);
  assign io_write_n                      = ~(io_write_p1 & address_enable_n);
  assign memory_read_n                   = ~(mem_read_p1 & address_enable_n);
  assign memory_write_n                  = ~(mem_write_p1 & address_enable_n);
  assign interrupt_acknowledge_n         = ~(inta_p1 & address_enable_n);

endmodule

// File: tb/tb_bus_command_generator.sv
// Directed bench for bus_command_generator (WAIT_TIMEOUT=4); expectations follow
// ADVANCED_WRITE_EN when the macro is defined for the build.
module tb_bus_command_generator;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] processor_status;
  logic       processor_ready;
  logic       address_enable_n;
  logic       address_latch_enable, processor_transmit_or_receive_n, data_enable;
  logic       io_read_n, io_write_n, memory_read_n, memory_write_n, interrupt_acknowledge_n;
  logic       bus_cycle_active, halt_detected, bus_timeout;
  logic [4:0] strobes;

  int n_cmp = 0;
  int n_err = 0;

  bus_command_generator #(.WAIT_TIMEOUT(4), .TIMER_WIDTH(10)) dut (
    .clock                           (clock),
    .reset                           (reset),
    .processor_status                (processor_status),
    .processor_ready                 (processor_ready),
    .address_enable_n                (address_enable_n),
    .address_latch_enable            (address_latch_enable),
    .processor_transmit_or_receive_n (processor_transmit_or_receive_n),
    .data_enable                     (data_enable),
    .io_read_n                       (io_read_n),
    .io_write_n                      (io_write_n),
    .memory_read_n                   (memory_read_n),
    .memory_write_n                  (memory_write_n),
    .interrupt_acknowledge_n         (interrupt_acknowledge_n),
    .bus_cycle_active                (bus_cycle_active),
    .halt_detected                   (halt_detected),
    .bus_timeout                     (bus_timeout)
  );

  always #5 clock = ~clock;

  // {io_read_n, io_write_n, memory_read_n, memory_write_n, interrupt_acknowledge_n}
  assign strobes = {io_read_n, io_write_n, memory_read_n, memory_write_n, interrupt_acknowledge_n};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int low_cnt;
    int to_seen;

    reset            = 1'b1;
    processor_status = 3'b111;
    processor_ready  = 1'b1;
    address_enable_n = 1'b1;
    tick();
    tick();
    check_val("rst_strobes", strobes, 5'b11111);
    check_val("rst_ctrl", {address_latch_enable, processor_transmit_or_receive_n, data_enable,
                           bus_cycle_active, halt_detected, bus_timeout}, 6'b000000);
    reset = 1'b0;
    tick();

    // Memory read, zero waits; status stays non-passive to show no second start.
    processor_status = 3'b101;
    tick();
    check_val("mr_t1_ale", address_latch_enable, 1'b1);
    check_val("mr_t1_strobes", strobes, 5'b11111);
    check_val("mr_t1_bca", bus_cycle_active, 1'b1);
    tick();
    check_val("mr_t2_strobes", strobes, 5'b11011);
    check_val("mr_t2_den_ale", {data_enable, address_latch_enable}, 2'b10);
    tick();
    check_val("mr_t3_strobes", strobes, 5'b11011);
    tick();
    check_val("mr_t4_strobes", strobes, 5'b11111);
    check_val("mr_t4_den_dtr_bca", {data_enable, processor_transmit_or_receive_n, bus_cycle_active}, 3'b001);
    tick();
    check_val("mr_idle_bca", bus_cycle_active, 1'b0);
    tick();
    check_val("mr_no_restart", {bus_cycle_active, address_latch_enable}, 2'b00);
    processor_status = 3'b111;
    tick();

    // I/O read with four Tw clocks: strobe low T2, T3, Tw x4.
    processor_status = 3'b001;
    tick();
    check_val("ior_t1_ale", address_latch_enable, 1'b1);
    processor_status = 3'b111;
    processor_ready  = 1'b0;
    low_cnt = 0;
    to_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!io_read_n) low_cnt++;
      if (bus_timeout) to_seen = 1;
      if (i == 5) processor_ready = 1'b1;
    end
    check_val("ior_low_clocks", low_cnt, 6);
    check_val("ior_no_timeout", to_seen, 0);
    check_val("ior_end_idle", bus_cycle_active, 1'b0);

    // Memory write: DT/R# from T1; strobe from T3 (T2 with the macro).
    processor_status = 3'b110;
    tick();
    check_val("mw_t1_dtr", processor_transmit_or_receive_n, 1'b1);
    check_val("mw_t1_strobes", strobes, 5'b11111);
    processor_status = 3'b111;
    tick();
`ifdef ADVANCED_WRITE_EN
    check_val("mw_t2_strobes", strobes, 5'b11101);
`else
    check_val("mw_t2_strobes", strobes, 5'b11111);
`endif
    check_val("mw_t2_den", data_enable, 1'b1);
    tick();
    check_val("mw_t3_strobes", strobes, 5'b11101);
    tick();
    check_val("mw_t4_strobes", strobes, 5'b11111);
    check_val("mw_t4_dtr", processor_transmit_or_receive_n, 1'b1);
    tick();

    // Halt: ALE and halt_detected pulse once, back to idle.
    processor_status = 3'b011;
    tick();
    check_val("halt_t1", {address_latch_enable, halt_detected, strobes}, 7'b1111111);
    check_val("halt_t1_dtr", processor_transmit_or_receive_n, 1'b0);
    processor_status = 3'b111;
    tick();
    check_val("halt_after", {address_latch_enable, halt_detected, bus_cycle_active, data_enable}, 4'b0000);
    check_val("halt_after_strobes", strobes, 5'b11111);
    tick();

    // I/O write with AEN pulled low in T3.
    processor_status = 3'b010;
    tick();
    processor_status = 3'b111;
    tick();
    tick();
    check_val("iow_t3_strobes", strobes, 5'b10111);
    address_enable_n = 1'b0;
    #1;
    check_val("iow_aen_gate", io_write_n, 1'b1);
    tick();
    check_val("iow_t4_bca", bus_cycle_active, 1'b1);
    check_val("iow_t4_strobes", strobes, 5'b11111);
    address_enable_n = 1'b1;
    tick();
    check_val("iow_idle", bus_cycle_active, 1'b0);

    // Timeout: ALE suppressed under AEN, then READY held low past four Tw clocks.
    processor_status = 3'b101;
    address_enable_n = 1'b0;
    tick();
    check_val("to_t1_ale_gated", {address_latch_enable, bus_cycle_active}, 2'b01);
    address_enable_n = 1'b1;
    processor_status = 3'b111;
    processor_ready  = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_val("to_tw4_strobe", {memory_read_n, bus_timeout}, 2'b00);
    tick();
    check_val("to_pulse", bus_timeout, 1'b1);
    check_val("to_release", strobes, 5'b11111);
    tick();
    check_val("to_pulse_end", {bus_timeout, bus_cycle_active}, 2'b00);

    // Reset mid-Tw.
    processor_status = 3'b001;
    tick();
    processor_status = 3'b111;
    for (int i = 0; i < 4; i++) tick();
    check_val("rstmid_tw_strobe", io_read_n, 1'b0);
    reset = 1'b1;
    tick();
    check_val("rstmid_strobes", strobes, 5'b11111);
    check_val("rstmid_ctrl", {address_latch_enable, processor_transmit_or_receive_n, data_enable,
                              bus_cycle_active, halt_detected, bus_timeout}, 6'b000000);
    reset = 1'b0;
    processor_ready = 1'b1;
    tick();
    tick();
    check_val("rstmid_idle", bus_cycle_active, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
